// File: rtl/pic_pkg.sv
// pic_pkg: shared types, constants and helpers for the 8259 control path.
//   inta_state_t  - acknowledge sequencer FSM states
//   CALL_OPCODE   - 8080 CALL opcode driven on the first INTA pulse
//   onehot2bin    - one-hot request to binary IR level (lowest set bit wins)
//   bin2onehot    - binary IR level to one-hot ISR/IRR mask
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_PULSE,
        ST_GAP
    } inta_state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    // Descending scan so the lowest set bit is the last one written.
    function automatic logic [2:0] onehot2bin(input logic [7:0] oh);
        logic [2:0] b;
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            if (oh[i]) b = 3'(i);
        end
        return b;
    endfunction

    function automatic logic [7:0] bin2onehot(input logic [2:0] b);
        return 8'(1) << b;
    endfunction

endpackage

// File: rtl/pic_inta_sync.sv
// pic_inta_sync: synchronizes the asynchronous INTA strobe and produces
// registered single-cycle fall/rise pulses.
//   i_clk, i_reset  - system clock, synchronous active-high reset
//   i_inta_n        - asynchronous active-low acknowledge pin
//   o_fall, o_rise  - one-cycle pulses, SYNC_STAGES+1 clocks after the pin edge
// Reset preloads every flop to 1 (strobe idle) so no false edge is seen.
module pic_inta_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inta_n,
    output logic o_fall,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_fall;
    logic                   r_rise;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '1;
            r_last <= 1'b1;
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_inta_n};
            r_last <= w_sync;
            r_fall <= r_last & ~w_sync;
            r_rise <= ~r_last & w_sync;
        end
    end

    assign o_fall = r_fall;
    assign o_rise = r_rise;

endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8259 interrupt-acknowledge handshake sequencer.
// Raises INT for a resolved request, counts INTA pulses, freezes the IRR,
// latches the ISR bit, drives CALL/vector bytes and signals end-of-acknowledge.
// Optional feature macro: PIC_INTA_AEOI_EN (automatic EOI clear mask output).
// Ports:
//   i_clk, i_reset         - clock, synchronous active-high reset
//   i_int_pending          - unmasked request above the ISR is pending
//   i_highest_req[7:0]     - one-hot winning request (0 = none)
//   i_inta_n               - asynchronous active-low INTA strobe
//   i_mode_8086            - 1: 8086 (2 pulses), 0: 8080 (3 pulses)
//   i_icw1_addr[2:0]       - ICW1 A7..A5
//   i_icw1_adi             - 1: call interval 4, 0: interval 8
//   i_icw2[7:0]            - T7..T3 (8086) or A15..A8 (8080)
//   i_aeoi                 - ICW4 AEOI
//   o_int_out              - INT pin
//   o_freeze               - hold IRR sampling during acknowledge
//   o_latch_in_service     - one-cycle ISR set pulse
//   o_in_service_set[7:0]  - one-hot ISR bit, valid with the pulse
//   o_data_out[7:0]        - data buffer byte
//   o_data_oe              - drive the bus
//   o_end_of_ack           - one-cycle pulse after the final INTA rises
//   o_ack_level[2:0]       - last captured IR level
//   o_aeoi_clear[7:0]      - one-cycle ISR clear mask with end_of_ack
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_int_pending,
    input  logic [7:0] i_highest_req,
    input  logic       i_inta_n,
    input  logic       i_mode_8086,
    input  logic [2:0] i_icw1_addr,
    input  logic       i_icw1_adi,
    input  logic [7:0] i_icw2,
    input  logic       i_aeoi,
    output logic       o_int_out,
    output logic       o_freeze,
    output logic       o_latch_in_service,
    output logic [7:0] o_in_service_set,
    output logic [7:0] o_data_out,
    output logic       o_data_oe,
    output logic       o_end_of_ack,
    output logic [2:0] o_ack_level,
    output logic [7:0] o_aeoi_clear
);
    inta_state_t r_state, w_state_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic        w_fall, w_rise;

    // Shadow copies of the configuration, taken at the first INTA fall.
    logic        r_mode;
    logic [2:0]  r_addr;
    logic        r_adi;
    logic [7:0]  r_icw2;
    logic        r_spur;
    logic [2:0]  r_level;

    logic        r_latch, w_latch_nxt;
    logic [7:0]  r_isr, w_isr_nxt;
    logic        r_eoa, w_eoa_nxt;
    logic        w_capture;
    logic        w_cap_spur;
    logic [2:0]  w_cap_level;
    logic [1:0]  w_last_cnt;

    pic_inta_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_inta_n (i_inta_n),
        .o_fall   (w_fall),
        .o_rise   (w_rise)
    );

    // A request that vanished before the first INTA still gets a vector.
    assign w_cap_spur  = ~i_int_pending | (i_highest_req == 8'h00);
    assign w_cap_level = w_cap_spur ? 3'(SPURIOUS_LEVEL) : onehot2bin(i_highest_req);
    assign w_last_cnt  = r_mode ? 2'd2 : 2'd3;

`ifdef PIC_INTA_AEOI_EN
    logic       r_aeoi;
    logic [7:0] r_clr, w_clr_nxt;
`else
    logic       w_unused_aeoi;
    assign w_unused_aeoi = i_aeoi;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_addr  <= '0;
            r_adi   <= 1'b0;
            r_icw2  <= '0;
            r_spur  <= 1'b0;
            r_level <= '0;
            r_latch <= 1'b0;
            r_isr   <= '0;
            r_eoa   <= 1'b0;
`ifdef PIC_INTA_AEOI_EN
            r_aeoi  <= 1'b0;
            r_clr   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_latch <= w_latch_nxt;
            r_isr   <= w_isr_nxt;
            r_eoa   <= w_eoa_nxt;
`ifdef PIC_INTA_AEOI_EN
            r_clr   <= w_clr_nxt;
`endif
            if (w_capture) begin
                r_mode  <= i_mode_8086;
                r_addr  <= i_icw1_addr;
                r_adi   <= i_icw1_adi;
                r_icw2  <= i_icw2;
                r_spur  <= w_cap_spur;
                r_level <= w_cap_level;
`ifdef PIC_INTA_AEOI_EN
                r_aeoi  <= i_aeoi;
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_latch_nxt = 1'b0;
        w_isr_nxt   = '0;
        w_eoa_nxt   = 1'b0;
`ifdef PIC_INTA_AEOI_EN
        w_clr_nxt   = '0;
`endif
        case (r_state)
            // INTA edges in IDLE are deliberately ignored.
            ST_IDLE: begin
                if (i_int_pending) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (w_fall) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 2'd1;
                    w_state_nxt = ST_PULSE;
                    if (!w_cap_spur) begin
                        w_latch_nxt = 1'b1;
                        w_isr_nxt   = bin2onehot(w_cap_level);
                    end
                end
            end
            ST_PULSE: begin
                if (w_rise) begin
                    if (r_cnt == w_last_cnt) begin
                        w_state_nxt = ST_IDLE;
                        w_eoa_nxt   = 1'b1;
`ifdef PIC_INTA_AEOI_EN
                        if (r_aeoi && !r_spur) w_clr_nxt = bin2onehot(r_level);
`endif
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_fall) begin
                    w_cnt_nxt   = r_cnt + 2'd1;
                    w_state_nxt = ST_PULSE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus byte for the current pulse, decoded from the shadowed configuration.
    always_comb begin
        o_data_out = '0;
        o_data_oe  = 1'b0;
        if (r_state == ST_PULSE) begin
            if (r_mode) begin
                if (r_cnt == 2'd2) begin
                    o_data_oe  = 1'b1;
                    o_data_out = {r_icw2[7:3], r_level};
                end
            end else begin
                case (r_cnt)
                    2'd1: begin
                        o_data_oe  = 1'b1;
                        o_data_out = CALL_OPCODE;
                    end
                    2'd2: begin
                        o_data_oe  = 1'b1;
                        o_data_out = r_adi ? {r_addr, r_level, 2'b00}
                                           : {r_addr[2:1], r_level, 3'b000};
                    end
                    2'd3: begin
                        o_data_oe  = 1'b1;
                        o_data_out = r_icw2;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_int_out          = (r_state == ST_REQ);
    assign o_freeze           = (r_state == ST_PULSE) || (r_state == ST_GAP);
    assign o_latch_in_service = r_latch;
    assign o_in_service_set   = r_isr;
    assign o_end_of_ack       = r_eoa;
    assign o_ack_level        = r_level;
`ifdef PIC_INTA_AEOI_EN
    assign o_aeoi_clear       = r_clr;
`else
    assign o_aeoi_clear       = '0;
`endif

endmodule

// File: tb/tb_pic_inta_sequencer.sv
module tb_pic_inta_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       int_pending = 1'b0;
    logic [7:0] highest_req = '0;
    logic       inta_n = 1'b1;
    logic       mode_8086 = 1'b0;
    logic [2:0] icw1_addr = '0;
    logic       icw1_adi = 1'b0;
    logic [7:0] icw2 = '0;
    logic       aeoi = 1'b0;
    logic       o_int, o_freeze, o_latch, o_oe, o_eoa;
    logic [7:0] o_isr, o_data, o_clr;
    logic [2:0] o_lvl;

    pic_inta_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_int_pending(int_pending),
        .i_highest_req(highest_req), .i_inta_n(inta_n), .i_mode_8086(mode_8086),
        .i_icw1_addr(icw1_addr), .i_icw1_adi(icw1_adi), .i_icw2(icw2), .i_aeoi(aeoi),
        .o_int_out(o_int), .o_freeze(o_freeze), .o_latch_in_service(o_latch),
        .o_in_service_set(o_isr), .o_data_out(o_data), .o_data_oe(o_oe),
        .o_end_of_ack(o_eoa), .o_ack_level(o_lvl), .o_aeoi_clear(o_clr)
    );

    always #5 clk = ~clk;

    localparam int K_LATCH = 1, K_DATA = 2, K_EOA = 3;
    typedef struct { int kind; logic [15:0] val; } ev_t;
    ev_t sb[$];
    int  checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int k, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic got(input int k, input logic [15:0] v);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=kind%0d:%h required=none t=%0t", k, v, $time);
        end else begin
            e = sb.pop_front();
            chk("event", {k[15:0], v}, {e.kind[15:0], e.val});
        end
    endtask

    // Monitor: every observable DUT event is matched against the scoreboard.
    logic prev_oe = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (o_latch) got(K_LATCH, {8'h00, o_isr});
            if (o_oe && !prev_oe) got(K_DATA, {8'h00, o_data});
            if (o_eoa) got(K_EOA, {5'b0, o_lvl, o_clr});
            if (!o_eoa) chk("aeoi_clear_idle", {24'h0, o_clr}, 32'h0);
        end
        prev_oe <= o_oe;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_int(input string tag);
        int t = 0;
        while (!o_int && t < 50) begin
            cyc(1);
            t++;
        end
        chk({tag, "_int_out"}, {31'h0, o_int}, 32'h1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {o_int, o_freeze, o_latch, o_oe, o_eoa, o_lvl},
            {27'h0, 5'h0});
        chk({tag, "_bytes"}, {o_isr, o_data, o_clr}, 32'h0);
    endtask

    // One full acknowledge sequence. d1..d3: expected bus bytes in order
    // (8086 uses d1 only). mutate flips all config inputs after the first fall.
    task automatic run_seq(input string tag, input bit m86, input logic [2:0] addr,
                           input bit adi, input logic [7:0] v_icw2, input bit v_aeoi,
                           input logic [7:0] req, input bit spur, input bit mutate,
                           input logic [7:0] e_isr, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input logic [2:0] e_lvl, input logic [7:0] e_clr);
        int n;
        mode_8086 = m86; icw1_addr = addr; icw1_adi = adi; icw2 = v_icw2; aeoi = v_aeoi;
        highest_req = req;
        int_pending = 1'b1;
        wait_int(tag);
        if (spur) begin
            int_pending = 1'b0;
            highest_req = 8'h00;
            cyc(4);
            chk({tag, "_int_hold"}, {31'h0, o_int}, 32'h1);
        end
        n = m86 ? 2 : 3;
        if (!spur) expect_ev(K_LATCH, {8'h00, e_isr});
        expect_ev(K_DATA, {8'h00, d1});
        if (!m86) begin
            expect_ev(K_DATA, {8'h00, d2});
            expect_ev(K_DATA, {8'h00, d3});
        end
        expect_ev(K_EOA, {5'b0, e_lvl, e_clr});
        for (int p = 1; p <= n; p++) begin
            inta_n = 1'b0;
            cyc(6);
            chk({tag, "_freeze_pulse"}, {31'h0, o_freeze}, 32'h1);
            chk({tag, "_int_low"}, {31'h0, o_int}, 32'h0);
            if (p == 1) begin
                int_pending = 1'b0;
                highest_req = 8'h00;
                if (mutate) begin
                    mode_8086 = ~m86; icw2 = ~v_icw2; icw1_addr = ~addr;
                    icw1_adi = ~adi; aeoi = ~v_aeoi;
                end
            end
            inta_n = 1'b1;
            cyc(6);
            if (p < n) chk({tag, "_freeze_gap"}, {31'h0, o_freeze}, 32'h1);
        end
        chk({tag, "_freeze_end"}, {31'h0, o_freeze}, 32'h0);
        chk({tag, "_ack_level"}, {29'h0, o_lvl}, {29'h0, e_lvl});
        chk({tag, "_sb_drained"}, sb.size(), 32'h0);
        cyc(2);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    logic [7:0] aeoi_exp;

    initial begin
`ifdef PIC_INTA_AEOI_EN
        aeoi_exp = 8'h04;
`else
        aeoi_exp = 8'h00;
`endif
        cyc(3);
        chk_all_zero("reset_state");
        reset = 1'b0;
        cyc(3);
        chk_all_zero("post_reset_idle");

        // 8086 IR3
        run_seq("t1_8086", 1'b1, 3'b000, 1'b0, 8'h40, 1'b0, 8'h08, 1'b0, 1'b0,
                8'h08, 8'h43, 8'h00, 8'h00, 3'd3, 8'h00);
        // 8080 IR5 interval 4
        run_seq("t2_8080_adi1", 1'b0, 3'b101, 1'b1, 8'h12, 1'b0, 8'h20, 1'b0, 1'b0,
                8'h20, 8'hCD, 8'hB4, 8'h12, 3'd5, 8'h00);
        // 8080 IR3 interval 8
        run_seq("t2b_8080_adi0", 1'b0, 3'b011, 1'b0, 8'h34, 1'b0, 8'h08, 1'b0, 1'b0,
                8'h08, 8'hCD, 8'h58, 8'h34, 3'd3, 8'h00);
        // spurious: request withdrawn before INTA
        run_seq("t3_spurious", 1'b1, 3'b000, 1'b0, 8'h48, 1'b1, 8'h02, 1'b1, 1'b0,
                8'h00, 8'h4F, 8'h00, 8'h00, 3'd7, 8'h00);
        // AEOI IR2
        run_seq("t4_aeoi", 1'b1, 3'b000, 1'b0, 8'h80, 1'b1, 8'h04, 1'b0, 1'b0,
                8'h04, 8'h82, 8'h00, 8'h00, 3'd2, aeoi_exp);

        // reset in the gap after pulse 2 of an 8080 sequence
        mode_8086 = 1'b0; icw1_addr = 3'b101; icw1_adi = 1'b1; icw2 = 8'h12;
        highest_req = 8'h20; int_pending = 1'b1;
        wait_int("t5");
        expect_ev(K_LATCH, 16'h0020);
        expect_ev(K_DATA, 16'h00CD);
        expect_ev(K_DATA, 16'h00B4);
        for (int p = 1; p <= 2; p++) begin
            inta_n = 1'b0;
            cyc(6);
            int_pending = 1'b0;
            highest_req = 8'h00;
            inta_n = 1'b1;
            cyc(6);
        end
        chk("t5_in_gap_freeze", {31'h0, o_freeze}, 32'h1);
        reset = 1'b1;
        cyc(1);
        chk_all_zero("t5_reset_mid");
        reset = 1'b0;
        chk("t5_sb_drained", sb.size(), 32'h0);
        cyc(3);
        run_seq("t5_after", 1'b0, 3'b101, 1'b1, 8'h12, 1'b0, 8'h20, 1'b0, 1'b0,
                8'h20, 8'hCD, 8'hB4, 8'h12, 3'd5, 8'h00);

        // INTA while idle: nothing may happen
        int_pending = 1'b0;
        for (int p = 0; p < 2; p++) begin
            inta_n = 1'b0;
            cyc(6);
            chk("t6_idle_freeze", {31'h0, o_freeze}, 32'h0);
            inta_n = 1'b1;
            cyc(6);
            chk("t6_idle_int", {31'h0, o_int}, 32'h0);
        end
        // configuration changes mid-sequence are ignored
        run_seq("t6_mutate", 1'b1, 3'b010, 1'b1, 8'hF8, 1'b0, 8'h01, 1'b0, 1'b1,
                8'h01, 8'hF8, 8'h00, 8'h00, 3'd0, 8'h00);

        cyc(4);
        chk("final_sb_drained", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
